imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time program loader and access controller for the pipeline's instruction memory. It receives a byte stream (header plus little-endian instruction words) over a valid/ready port, writes each assembled 32-bit word into consecutive instruction-memory word addresses, and holds the fetch stage stalled until the image is complete. After a successful load the memory belongs to the pipeline; a new `start` pulse reclaims it for reloading.

## Interface
Parameters:
- `DEPTH`, 128: instruction memory size in 32-bit words.
- `AW`, 7: word-address width, with 2^AW ≥ DEPTH.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `start`  in  1  one-cycle request to begin a load.
- `byte_valid`  in  1  `byte_data` holds a valid byte.
- `byte_data`  in  8  stream byte.
- `byte_ready`  out  1  loader accepts a byte this cycle.
- `mem_we`  out  1  instruction-memory write strobe, one cycle per word.
- `mem_waddr`  out  AW  word address; byte address = `mem_waddr` × 4.
- `mem_wdata`  out  32  instruction word.
- `core_stall`  out  1  holds PC/fetch while the memory is owned by the loader.
- `load_done`  out  1  image loaded successfully; level signal.
- `load_err`  out  1  header word count exceeded DEPTH; level signal.
- `words_loaded`  out  16  number of words written in the current or last load.

## Operation
- Stream format: byte 0 = N[7:0], byte 1 = N[15:8], then 4·N bytes. Each word arrives LSB first: `wdata = {b3,b2,b1,b0}`.
- A byte transfers on a cycle with `byte_valid & byte_ready`.
- FSM states: IDLE, HDR0, HDR1, DATA, DONE, ERR.
  - IDLE: `start` → HDR0.
  - HDR0: on a transfer, latch the low byte of N → HDR1.
  - HDR1: on a transfer, latch the high byte of N. If N == 0 → DONE. If N > DEPTH → ERR. Otherwise clear the word counter and byte index → DATA.
  - DATA: on each transfer, shift the byte into the assembly register and increment the 2-bit byte index. When the index is 3, issue a write at address = word counter, then increment the word counter. If that write was word N−1 → DONE.
  - DONE / ERR: `start` → HDR0. In that cycle `load_done` and `load_err` clear and `words_loaded` resets to 0.
- `start` is ignored in HDR0, HDR1 and DATA.
- `byte_ready` = 1 only in HDR0, HDR1 and DATA.
- `core_stall` = 1 in every state except DONE.
- `load_err` = 1 only in ERR. No memory write ever occurs for a rejected image.
- `words_loaded` saturates at N and is never greater than DEPTH.
- Addresses are written strictly increasing from 0. There is no wrap-around because N ≤ DEPTH is enforced before any write.

## Timing
- Reset values: state IDLE, `byte_ready`=0, `mem_we`=0, `mem_waddr`=0, `mem_wdata`=0, `core_stall`=1, `load_done`=0, `load_err`=0, `words_loaded`=0. Byte index, word counter and N are all cleared.
- Reset takes priority over every other input and is sampled only on a `clk` edge.
  - Reset during DATA discards the partial word. No `mem_we` is issued on the cycle after reset.
  - Words already written stay in memory; the loader does not erase them.
- `start` → HDR0 takes effect on the next edge. `byte_ready` rises in the cycle after `start` is sampled.
- `mem_we`, `mem_waddr` and `mem_wdata` are registered. The write strobe is high exactly one cycle, in the cycle after the 4th byte of a word is accepted.
- Maximum throughput is one byte per cycle, so `mem_we` pulses at most once every 4 cycles.
- Final word:
  - Cycle T: the last byte is accepted.
  - T+1: `mem_we`=1 and state = DONE. `byte_ready`=0 from T+1.
  - T+2: `core_stall`=0 and `load_done`=1. `core_stall` is registered from state == DONE, so the stall falls one cycle after the last write lands.
- N == 0: `load_done`=1 and `core_stall`=0 two cycles after the HDR1 byte is accepted.
- Bytes offered while `byte_ready`=0 are not consumed; the source must hold them.
- `start` coinciding with a byte transfer in DONE: `start` wins and the byte is not accepted, because `byte_ready`=0 in DONE.

## Test plan
- Reset, then `start`, then stream 02 00 | 13 01 01 FE | B3 07 F7 00 at one byte per cycle. Required:
  - `mem_we` pulses at addr 0 with 0xFE010113, then at addr 1 with 0x00F707B3.
  - `words_loaded`=2, `load_done`=1.
  - `core_stall` falls 1 cycle after the second `mem_we`.
- Same image with `byte_valid` toggled every other cycle. Required: identical writes, `byte_ready` never drops mid-load, and no bytes are lost or duplicated.
- Header 81 00 (N=129 > 128). Required: ERR state, `load_err`=1, `core_stall` stays 1, zero `mem_we` pulses. A following `start` clears `load_err`.
- Header 00 00 (N=0). Required: `load_done`=1 and `core_stall`=0 two cycles after the second header byte, with no writes.
- Assert `rst_n`=0 for one cycle after 2 bytes of word 1 (N=3). Required: the next cycle shows all reset values and no `mem_we`. A fresh `start` and full image then load correctly from addr 0.
- `start` pulsed during DATA is ignored. `start` pulsed in DONE reloads: `load_done` drops and `core_stall`=1 on the next cycle.

Source files
------------

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: assembles a length-prefixed little-endian
// byte stream into 32-bit words, writes them from address 0 and stalls fetch until done.
module imem_loader #(
    parameter int DEPTH = 128,
    parameter int AW    = 7
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          byte_valid,
    input  logic [7:0]    byte_data,
    output logic          byte_ready,
    output logic          mem_we,
    output logic [AW-1:0] mem_waddr,
    output logic [31:0]   mem_wdata,
    output logic          core_stall,
    output logic          load_done,
    output logic          load_err,
    output logic [15:0]   words_loaded
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR0 = 3'd1,
        HDR1 = 3'd2,
        DATA = 3'd3,
        DONE = 3'd4,
        ERR  = 3'd5
    } state_t;

    localparam logic [15:0] DEPTH_W = 16'(DEPTH);

    state_t        state_q, state_d;
    logic [15:0]   n_q, n_d;
    logic [15:0]   word_cnt_q, word_cnt_d;
    logic [1:0]    byte_idx_q, byte_idx_d;
    logic [23:0]   asm_q, asm_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_waddr_q, mem_waddr_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic          core_stall_q, core_stall_d;
    logic          load_done_q, load_done_d;
    logic          xfer;
    logic [15:0]   n_full;

    assign byte_ready   = (state_q == HDR0) || (state_q == HDR1) || (state_q == DATA);
    assign xfer         = byte_valid && byte_ready;
    assign n_full       = {byte_data, n_q[7:0]};
    assign mem_we       = mem_we_q;
    assign mem_waddr    = mem_waddr_q;
    assign mem_wdata    = mem_wdata_q;
    assign core_stall   = core_stall_q;
    assign load_done    = load_done_q;
    assign load_err     = (state_q == ERR);
    assign words_loaded = word_cnt_q;

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        word_cnt_d  = word_cnt_q;
        byte_idx_d  = byte_idx_q;
        asm_d       = asm_q;
        mem_we_d    = 1'b0;
        mem_waddr_d = mem_waddr_q;
        mem_wdata_d = mem_wdata_q;
        // A start seen in DONE hands the memory back to the loader on the next edge.
        load_done_d  = (state_q == DONE) && !start;
        core_stall_d = !load_done_d;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = HDR0;
                end
            end
            HDR0: begin
                if (xfer) begin
                    n_d[7:0] = byte_data;
                    state_d  = HDR1;
                end
            end
            HDR1: begin
                if (xfer) begin
                    n_d = n_full;
                    if (n_full == 16'd0) begin
                        state_d = DONE;
                    end else if (n_full > DEPTH_W) begin
                        state_d = ERR;
                    end else begin
                        word_cnt_d = 16'd0;
                        byte_idx_d = 2'd0;
                        state_d    = DATA;
                    end
                end
            end
            DATA: begin
                if (xfer) begin
                    asm_d      = {byte_data, asm_q[23:8]};
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        mem_we_d    = 1'b1;
                        mem_waddr_d = word_cnt_q[AW-1:0];
                        mem_wdata_d = {byte_data, asm_q};
                        word_cnt_d  = word_cnt_q + 16'd1;
                        if (word_cnt_q + 16'd1 == n_q) begin
                            state_d = DONE;
                        end
                    end
                end
            end
            DONE, ERR: begin
                if (start) begin
                    state_d    = HDR0;
                    word_cnt_d = 16'd0;
                    byte_idx_d = 2'd0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            n_q          <= 16'd0;
            word_cnt_q   <= 16'd0;
            byte_idx_q   <= 2'd0;
            asm_q        <= 24'd0;
            mem_we_q     <= 1'b0;
            mem_waddr_q  <= '0;
            mem_wdata_q  <= 32'd0;
            core_stall_q <= 1'b1;
            load_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            n_q          <= n_d;
            word_cnt_q   <= word_cnt_d;
            byte_idx_q   <= byte_idx_d;
            asm_q        <= asm_d;
            mem_we_q     <= mem_we_d;
            mem_waddr_q  <= mem_waddr_d;
            mem_wdata_q  <= mem_wdata_d;
            core_stall_q <= core_stall_d;
            load_done_q  <= load_done_d;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed corner cases plus a table of
// randomized image loads scored against an expected-write queue.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n, start, byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready, mem_we, core_stall, load_done, load_err;
    logic [6:0]  mem_waddr;
    logic [31:0] mem_wdata;
    logic [15:0] words_loaded;

    imem_loader #(.DEPTH(128), .AW(7)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .core_stall(core_stall), .load_done(load_done), .load_err(load_err),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [6:0]  addr;
        logic [31:0] data;
    } wr_t;
    wr_t exp_q[$];
    logic [31:0] w [0:127];
    logic prev_we = 1'b0;

    typedef struct {
        int n;
        int mode;      // 0 back-to-back, 1 valid toggling, 2 random gaps
        bit inj;       // pulse start mid-DATA
        bit exp_done;
        bit exp_err;
    } vec_t;
    vec_t tbl [0:10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Write scoreboard: every strobe must match the next expected word, one cycle wide.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && mem_we === 1'b1) begin
            wr_t e;
            checks++;
            if (prev_we) begin
                errors++;
                $display("FAIL we_width actual=back-to-back strobes required=single-cycle");
            end else if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write actual=addr %0d data %h required=no write", mem_waddr, mem_wdata);
            end else begin
                e = exp_q.pop_front();
                if (mem_waddr !== e.addr || mem_wdata !== e.data) begin
                    errors++;
                    $display("FAIL write actual=addr %0d data %h required=addr %0d data %h",
                             mem_waddr, mem_wdata, e.addr, e.data);
                end else begin
                    $display("write addr %0d data %h ok", mem_waddr, mem_wdata);
                end
            end
        end
        prev_we = (mem_we === 1'b1);
    end

    // Reference rule: a load of n words writes words 0..n-1 iff 0 < n <= DEPTH.
    function automatic int model_writes(input int n);
        return (n >= 1 && n <= 128) ? n : 0;
    endfunction

    task automatic idle(input int k, input bit chk);
        for (int i = 0; i < k; i++) begin
            @(negedge clk);
            if (chk) check("ready_mid_load", byte_ready, 1'b1);
            @(posedge clk); #1;
        end
    endtask

    task automatic gap(input int mode);
        if (mode == 1) idle(1, 1'b1);
        else if (mode == 2) idle($urandom_range(0, 2), 1'b1);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        @(negedge clk);
        while (byte_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) begin
            checks++;
            errors++;
            $display("FAIL byte_timeout actual=byte_ready low required=byte accepted");
        end
        @(posedge clk); #1;
        byte_valid = 1'b0;
        byte_data  = 8'($urandom);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_byte_ready"}, byte_ready, 1'b0);
        check({tag, "_mem_we"}, mem_we, 1'b0);
        check({tag, "_mem_waddr"}, mem_waddr, 7'd0);
        check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        check({tag, "_core_stall"}, core_stall, 1'b1);
        check({tag, "_load_done"}, load_done, 1'b0);
        check({tag, "_load_err"}, load_err, 1'b0);
        check({tag, "_words_loaded"}, words_loaded, 16'd0);
    endtask

    task automatic do_start(input bit with_byte);
        start = 1'b1;
        if (with_byte) begin
            byte_valid = 1'b1;
            byte_data  = 8'hAA;
        end
        @(posedge clk); #1;
        start      = 1'b0;
        byte_valid = 1'b0;
        check("start_byte_ready", byte_ready, 1'b1);
        check("start_core_stall", core_stall, 1'b1);
        check("start_load_done", load_done, 1'b0);
        check("start_load_err", load_err, 1'b0);
        check("start_words", words_loaded, 16'd0);
    endtask

    task automatic run_load(input int n, input int mode, input bit inj,
                            input bit exp_done, input bit exp_err, input bit with_byte);
        logic [15:0] nn;
        int nw;
        nn = 16'(n);
        nw = model_writes(n);
        for (int i = 0; i < nw; i++) exp_q.push_back('{addr: 7'(i), data: w[i]});
        do_start(with_byte);
        send_byte(nn[7:0]);
        gap(mode);
        send_byte(nn[15:8]);
        if (exp_err) begin
            check("err_flag", load_err, 1'b1);
            check("err_ready", byte_ready, 1'b0);
            check("err_stall", core_stall, 1'b1);
            byte_valid = 1'b1;
            idle(3, 1'b0);
            byte_valid = 1'b0;
            check("err_hold", load_err, 1'b1);
            check("err_stall_hold", core_stall, 1'b1);
            check("err_done", load_done, exp_done);
            check("err_words", words_loaded, 16'd0);
            check("err_no_writes", exp_q.size(), 0);
        end else if (nw == 0) begin
            check("n0_ready", byte_ready, 1'b0);
            check("n0_stall_t1", core_stall, 1'b1);
            idle(1, 1'b0);
            check("n0_done", load_done, exp_done);
            check("n0_stall", core_stall, 1'b0);
            check("n0_words", words_loaded, 16'd0);
        end else begin
            for (int i = 0; i < nw; i++) begin
                for (int k = 0; k < 4; k++) begin
                    send_byte(w[i][8*k +: 8]);
                    if (inj && i == 1 && k == 1) begin
                        start = 1'b1;
                        @(posedge clk); #1;
                        start = 1'b0;
                        check("inj_ready", byte_ready, 1'b1);
                        check("inj_stall", core_stall, 1'b1);
                    end
                    if (!(i == nw - 1 && k == 3)) gap(mode);
                end
            end
            check("last_we", mem_we, 1'b1);
            check("last_ready", byte_ready, 1'b0);
            check("last_stall_t1", core_stall, 1'b1);
            check("last_done_t1", load_done, 1'b0);
            idle(1, 1'b0);
            check("done_stall", core_stall, 1'b0);
            check("done_flag", load_done, exp_done);
            check("done_words", words_loaded, 16'(nw));
            check("done_all_written", exp_q.size(), 0);
            idle(2, 1'b0);
            check("done_words_sat", words_loaded, 16'(nw));
        end
        $display("load n=%0d mode=%0d inj=%0d done=%0d err=%0d words=%0d", n, mode, inj,
                 load_done, load_err, words_loaded);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{2, 0, 1'b0, 1'b1, 1'b0};
        tbl[1]  = '{2, 1, 1'b0, 1'b1, 1'b0};
        tbl[2]  = '{0, 0, 1'b0, 1'b1, 1'b0};
        tbl[3]  = '{129, 0, 1'b0, 1'b0, 1'b1};
        tbl[4]  = '{1, 2, 1'b0, 1'b1, 1'b0};
        tbl[5]  = '{128, 2, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{5, 1, 1'b1, 1'b1, 1'b0};
        tbl[7]  = '{256, 0, 1'b0, 1'b0, 1'b1};
        tbl[8]  = '{65535, 2, 1'b0, 1'b0, 1'b1};
        tbl[9]  = '{128, 0, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{3, 2, 1'b1, 1'b1, 1'b0};

        rst_n = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_data = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst_n = 1'b1;
        idle(1, 1'b0);

        // Reference program image, then the same image with valid toggling.
        w[0] = 32'hFE010113;
        w[1] = 32'h00F707B3;
        run_load(2, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        run_load(2, 1, 1'b0, 1'b1, 1'b0, 1'b0);

        // Reset in the middle of word 1 of a 3-word image.
        for (int i = 0; i < 3; i++) w[i] = $urandom;
        exp_q.push_back('{addr: 7'd0, data: w[0]});
        do_start(1'b0);
        send_byte(8'h03);
        send_byte(8'h00);
        for (int k = 0; k < 4; k++) send_byte(w[0][8*k +: 8]);
        send_byte(w[1][7:0]);
        send_byte(w[1][15:8]);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_reset_vals("midreset");
        check("midreset_word0_written", exp_q.size(), 0);
        idle(1, 1'b0);
        check("midreset_no_we", mem_we, 1'b0);
        for (int i = 0; i < 3; i++) w[i] = $urandom;
        run_load(3, 0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Start in DONE with a byte on the bus: the byte must not be consumed.
        for (int i = 0; i < 4; i++) w[i] = $urandom;
        run_load(4, 0, 1'b0, 1'b1, 1'b0, 1'b1);

        for (int t = 0; t < 11; t++) begin
            for (int i = 0; i < 128; i++) w[i] = $urandom;
            run_load(tbl[t].n, tbl[t].mode, tbl[t].inj, tbl[t].exp_done, tbl[t].exp_err, 1'b0);
        end

        // Error state must also clear on a following start.
        do_start(1'b0);
        check("post_err_flag", load_err, 1'b0);
        idle(2, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
